// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier datapath.
//   - Default exponent width / bias for half, single and double formats.
//   - exp_flags_t: special-case and range flags produced by the exponent path.
//   - exp_all_ones(): all-ones exponent value (inf/NaN encoding) for a width.
package fp_pkg;

  localparam int EXP_W_HALF   = 5;
  localparam int BIAS_HALF    = 15;
  localparam int EXP_W_SINGLE = 8;
  localparam int BIAS_SINGLE  = 127;
  localparam int EXP_W_DOUBLE = 11;
  localparam int BIAS_DOUBLE  = 1023;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } exp_flags_t;

  function automatic logic [63:0] exp_all_ones(input int exp_w);
    return (64'd1 << exp_w) - 64'd1;
  endfunction

endpackage

// File: rtl/exp_classify.sv
// Combinational classification of one biased exponent field.
// Ports:
//   exp_i      biased exponent
//   is_zero_o  exponent is zero (zero or denormal operand, flushed)
//   is_ones_o  exponent is all-ones (inf or NaN operand)
module exp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_SINGLE
) (
  input  logic [EXP_W-1:0] exp_i,
  output logic             is_zero_o,
  output logic             is_ones_o
);

  localparam logic [EXP_W-1:0] ALL_ONES = EXP_W'(exp_all_ones(EXP_W));

  assign is_zero_o = (exp_i == '0);
  assign is_ones_o = (exp_i == ALL_ONES);

endmodule

// File: rtl/exp_adder_pipe.sv
// Two-stage pipelined exponent path of the floating-point multiplier.
// Stage 1 classifies both operands and forms the unbiased-once sum
// a + b - BIAS + norm_inc at full (EXP_W+2)-bit signed precision.
// Stage 2 resolves special operands and overflow/underflow into the
// final biased exponent and one-hot flags.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake (exp_a, exp_b, norm_inc)
//   out_valid/out_ready           result handshake (exp_res + flags)
//   ovf/unf/is_zero/is_inf/is_nan result classification, at most one set
module exp_adder_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_SINGLE,
  parameter int BIAS  = BIAS_SINGLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             norm_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_res,
  output logic             ovf,
  output logic             unf,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  localparam int RAW_W = EXP_W + 2;
  localparam logic [EXP_W-1:0]        ALL_ONES = EXP_W'(exp_all_ones(EXP_W));
  localparam logic signed [RAW_W-1:0] RAW_OVF  = $signed({2'b00, ALL_ONES});
  localparam logic signed [RAW_W-1:0] RAW_ZERO = '0;
  localparam logic signed [RAW_W-1:0] BIAS_RAW = RAW_W'(BIAS);

  // Stage 1 classification
  logic za_d, zb_d, ia_d, ib_d;

  exp_classify #(.EXP_W(EXP_W)) u_cls_a (
    .exp_i     (exp_a),
    .is_zero_o (za_d),
    .is_ones_o (ia_d)
  );

  exp_classify #(.EXP_W(EXP_W)) u_cls_b (
    .exp_i     (exp_b),
    .is_zero_o (zb_d),
    .is_ones_o (ib_d)
  );

  // Zero-extend both operands so the sum cannot wrap before range checks.
  logic signed [RAW_W-1:0] raw_d;
  assign raw_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_RAW
               + $signed({{(RAW_W-1){1'b0}}, norm_inc});

  logic                    s1_valid_q;
  logic signed [RAW_W-1:0] s1_raw_q;
  logic                    s1_za_q, s1_zb_q, s1_ia_q, s1_ib_q;

  logic                    s2_valid_q;
  logic [EXP_W-1:0]        s2_exp_q;
  exp_flags_t              s2_flags_q;

  // Handshake and stage movement
  logic in_fire, s2_load, out_fire;
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  // Stage 2 resolution: special operands take priority over range checks.
  logic [EXP_W-1:0] s2_exp_d;
  exp_flags_t       s2_flags_d;
  logic             nan_c, zero_c, inf_c;

  always_comb begin
    nan_c      = (s1_za_q && s1_ib_q) || (s1_ia_q && s1_zb_q);
    zero_c     = (s1_za_q || s1_zb_q) && !nan_c;
    inf_c      = (s1_ia_q || s1_ib_q) && !nan_c && !zero_c;
    s2_flags_d = '0;
    s2_exp_d   = s1_raw_q[EXP_W-1:0];
    if (nan_c) begin
      s2_exp_d          = ALL_ONES;
      s2_flags_d.is_nan = 1'b1;
    end else if (zero_c) begin
      s2_exp_d           = '0;
      s2_flags_d.is_zero = 1'b1;
    end else if (inf_c) begin
      s2_exp_d          = ALL_ONES;
      s2_flags_d.is_inf = 1'b1;
    end else if (s1_raw_q >= RAW_OVF) begin
      s2_exp_d       = ALL_ONES;
      s2_flags_d.ovf = 1'b1;
    end else if (s1_raw_q <= RAW_ZERO) begin
      s2_exp_d       = '0;
      s2_flags_d.unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_za_q    <= 1'b0;
      s1_zb_q    <= 1'b0;
      s1_ia_q    <= 1'b0;
      s1_ib_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_exp_q   <= '0;
      s2_flags_q <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_raw_q   <= raw_d;
        s1_za_q    <= za_d;
        s1_zb_q    <= zb_d;
        s1_ia_q    <= ia_d;
        s1_ib_q    <= ib_d;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_exp_q   <= s2_exp_d;
        s2_flags_q <= s2_flags_d;
      end else if (out_fire) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign exp_res   = s2_exp_q;
  assign ovf       = s2_flags_q.ovf;
  assign unf       = s2_flags_q.unf;
  assign is_zero   = s2_flags_q.is_zero;
  assign is_inf    = s2_flags_q.is_inf;
  assign is_nan    = s2_flags_q.is_nan;

endmodule
